sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 hashing core. Accepts a message of NUM_OF_WORDS 32-bit words over a valid/ready stream and applies SHA-256 padding: a 0x80000000 word, zero fill, and a 64-bit big-endian bit length. It emits a sequence of 16-word blocks with first/last flags, in the same unpacked message[15:0] form the core loads in its BLOCK state. The block controller starts the core with hin = IV on blk_first and with the chained digest otherwise.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..65535.
NUM_BLOCKS, derived localparam (NUM_OF_WORDS+2)/16 + 1 (integer divide), number of blocks emitted per message.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a message; ignored unless state is IDLE
in_valid  input  1  in_data is valid
in_data  input  32  message word, first word first
in_ready  output  1  padder accepts in_data this cycle
blk_valid  output  1  blk_data holds a complete block
blk_data  output  32 x [15:0]  block words; index 0 is the first word
blk_first  output  1  block is block 0 of the message; qualified by blk_valid
blk_last  output  1  block is block NUM_BLOCKS-1; qualified by blk_valid
blk_ready  input  1  consumer takes the block
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse after the last block handshake

Behaviour:
- Reset (asynchronous): state=IDLE. in_ready, blk_valid, blk_first, blk_last, busy and done are 0. blk_data, all counters and the pad flag are 0.
- Counters: widx 0..15 is the word position in the current block. tcnt 0..NUM_OF_WORDS counts accepted data words. bidx 0..NUM_BLOCKS-1 is the block index. pad_done is set once 0x80000000 has been written.
- IDLE: done=0. On start, clear widx, tcnt, bidx and pad_done, then go to FILL.
- FILL: in_ready=1 iff tcnt<NUM_OF_WORDS.
  - On in_valid&&in_ready, write buf[widx]=in_data and increment widx and tcnt.
  - If widx was 15, go to EMIT.
  - Else, if tcnt reaches NUM_OF_WORDS, go to PAD.
  - If FILL is entered with tcnt==NUM_OF_WORDS, go directly to PAD.
- PAD: in_ready=0. Write exactly one word per cycle at buf[widx], then increment widx:
  - first PAD cycle of the message: 0x80000000, and set pad_done;
  - bidx==NUM_BLOCKS-1 and widx==14: 0x00000000 (upper length word);
  - bidx==NUM_BLOCKS-1 and widx==15: NUM_OF_WORDS*32, truncated to 32 bits;
  - every other position: 0x00000000.
  - After writing widx 15, go to EMIT.
- EMIT: blk_valid=1, blk_first=(bidx==0), blk_last=(bidx==NUM_BLOCKS-1).
  - blk_data, blk_first and blk_last stay stable while blk_valid=1 && !blk_ready.
  - On handshake, set widx=0.
  - If last: go to DONE.
  - Else: increment bidx; go to FILL if tcnt<NUM_OF_WORDS, otherwise to PAD.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: blk_valid rises on the cycle after the write to widx 15. No input word is accepted while a block is held in EMIT (single buffer, no overlap).
- Pad word at position NUM_OF_WORDS%16 = 14 or 15: the current block gets 0x80000000 and zero fill. One extra block follows, all zero except word 15 = bit length. NUM_BLOCKS covers this case.
- Exact multiple of 16 words: block k = NUM_OF_WORDS/16 starts with 0x80000000.
- in_valid while in_ready=0: ignored, with no side effects. Extra words beyond NUM_OF_WORDS are never consumed.
- start while busy: ignored.
- reset_n low mid-message: immediate return to IDLE. The partial block is discarded, and no done pulse is produced.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (logic [31:0]) and block_t (word_t [15:0]);
  - PAD_WORD = 32'h80000000;
  - the padder state enum {IDLE, FILL, PAD, EMIT, DONE};
  - function num_blocks(int words).
- No sub-module. A single flat module with one FSM and a 16-word buffer register is the natural size (about 200 lines).

Test Plan:
- NUM_OF_WORDS=20, in_data=i+1 for i=0..19, blk_ready=1 -> block0 = 1..16 with first=1, last=0. Block1 = 17,18,19,20, 0x80000000, zeros, [14]=0, [15]=0x00000280 with last=1. done pulses once.
- NUM_OF_WORDS=1, word 0xDEADBEEF -> a single block [0]=0xDEADBEEF, [1]=0x80000000, [2..14]=0, [15]=0x00000020, with first=last=1.
- NUM_OF_WORDS=14, words 1..14 -> block0 [14]=0x80000000, [15]=0. Block1 all zero except [15]=0x000001C0.
- NUM_OF_WORDS=16, words 1..16 -> block0 = 1..16. Block1 [0]=0x80000000, [15]=0x00000200.
- Backpressure with NUM_OF_WORDS=20: blk_ready=0 for 5 cycles during block0 -> blk_valid stays 1, blk_data is unchanged, and in_ready=0 throughout. Stalling in_valid for 3 cycles mid-FILL inserts no words.
- reset_n pulsed low after 7 words, then start with 20 fresh words -> all outputs 0 during reset. Output is identical to the first scenario. A start issued while busy changes nothing.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 core.
// Word/block types, pad word, padder states and block count.
package sha256_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [15:0] block_t;

   localparam word_t PAD_WORD = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      EMIT,
      DONE
   } pad_state_e;

   // Room for the pad word plus the two length words.
   function automatic int num_blocks(input int words);
      return (words + 2) / 16 + 1;
   endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: buffers input words into 16-word
// blocks, appends 0x80000000, zero fill and the bit length.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 20
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   start,
   input  logic   in_valid,
   input  word_t  in_data,
   output logic   in_ready,
   output logic   blk_valid,
   output block_t blk_data,
   output logic   blk_first,
   output logic   blk_last,
   input  logic   blk_ready,
   output logic   busy,
   output logic   done
);

   localparam int NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
   localparam logic [16:0] NW = 17'(NUM_OF_WORDS);
   localparam logic [15:0] LAST_B = 16'(NUM_BLOCKS - 1);
   localparam word_t LEN_WORD = 32'(NUM_OF_WORDS * 32);

   pad_state_e  state;
   logic [3:0]  widx;
   logic [16:0] tcnt;
   logic [15:0] bidx;
   logic        pad_done;
   word_t       pad_word;

   // Word written at the current position while padding.
   always_comb begin
      pad_word = '0;
      if (!pad_done)
         pad_word = PAD_WORD;
      else if (bidx == LAST_B && widx == 4'd15)
         pad_word = LEN_WORD;
   end

   // Padder FSM, block buffer and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         widx      <= '0;
         tcnt      <= '0;
         bidx      <= '0;
         pad_done  <= 1'b0;
         blk_data  <= '0;
         in_ready  <= 1'b0;
         blk_valid <= 1'b0;
         blk_first <= 1'b0;
         blk_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  widx     <= '0;
                  tcnt     <= '0;
                  bidx     <= '0;
                  pad_done <= 1'b0;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (tcnt == NW) begin
                  in_ready <= 1'b0;
                  state    <= PAD;
               end else if (in_valid && in_ready) begin
                  blk_data[widx] <= in_data;
                  widx <= widx + 4'd1;
                  tcnt <= tcnt + 17'd1;
                  if (widx == 4'd15) begin
                     in_ready  <= 1'b0;
                     blk_valid <= 1'b1;
                     blk_first <= (bidx == '0);
                     blk_last  <= (bidx == LAST_B);
                     state     <= EMIT;
                  end else if (tcnt + 17'd1 == NW) begin
                     in_ready <= 1'b0;
                     state    <= PAD;
                  end
               end
            end
            PAD: begin
               blk_data[widx] <= pad_word;
               pad_done <= 1'b1;
               widx <= widx + 4'd1;
               if (widx == 4'd15) begin
                  blk_valid <= 1'b1;
                  blk_first <= (bidx == '0);
                  blk_last  <= (bidx == LAST_B);
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (blk_ready) begin
                  blk_valid <= 1'b0;
                  blk_first <= 1'b0;
                  blk_last  <= 1'b0;
                  widx      <= '0;
                  if (blk_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     bidx <= bidx + 16'd1;
                     if (tcnt < NW) begin
                        in_ready <= 1'b1;
                        state    <= FILL;
                     end else begin
                        state <= PAD;
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: four instances with
// different message lengths, table-driven plus reset sequence.
module tb_sha256_msg_padder;
   import sha256_pkg::*;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   logic   start_v [4];
   logic   in_valid = 1'b0;
   word_t  in_data = '0;
   logic   blk_ready = 1'b1;
   logic   in_ready_v [4];
   logic   blk_valid_v [4];
   logic   blk_first_v [4];
   logic   blk_last_v [4];
   logic   busy_v [4];
   logic   done_v [4];
   block_t blk_data_v [4];

   always #5 clk = ~clk;

   sha256_msg_padder #(.NUM_OF_WORDS(20)) u0 (
      .clk(clk), .reset_n(reset_n), .start(start_v[0]),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_v[0]), .blk_valid(blk_valid_v[0]),
      .blk_data(blk_data_v[0]), .blk_first(blk_first_v[0]),
      .blk_last(blk_last_v[0]), .blk_ready(blk_ready),
      .busy(busy_v[0]), .done(done_v[0]));

   sha256_msg_padder #(.NUM_OF_WORDS(1)) u1 (
      .clk(clk), .reset_n(reset_n), .start(start_v[1]),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_v[1]), .blk_valid(blk_valid_v[1]),
      .blk_data(blk_data_v[1]), .blk_first(blk_first_v[1]),
      .blk_last(blk_last_v[1]), .blk_ready(blk_ready),
      .busy(busy_v[1]), .done(done_v[1]));

   sha256_msg_padder #(.NUM_OF_WORDS(14)) u2 (
      .clk(clk), .reset_n(reset_n), .start(start_v[2]),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_v[2]), .blk_valid(blk_valid_v[2]),
      .blk_data(blk_data_v[2]), .blk_first(blk_first_v[2]),
      .blk_last(blk_last_v[2]), .blk_ready(blk_ready),
      .busy(busy_v[2]), .done(done_v[2]));

   sha256_msg_padder #(.NUM_OF_WORDS(16)) u3 (
      .clk(clk), .reset_n(reset_n), .start(start_v[3]),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_v[3]), .blk_valid(blk_valid_v[3]),
      .blk_data(blk_data_v[3]), .blk_first(blk_first_v[3]),
      .blk_last(blk_last_v[3]), .blk_ready(blk_ready),
      .busy(busy_v[3]), .done(done_v[3]));

   typedef struct {
      int    dut;
      int    n;
      word_t w0;
      int    stall_at;
      int    bp;
      int    busy_start;
      int    exp_blocks;
      int    exp_pad;
      word_t exp_len;
   } vec_t;

   vec_t   vecs [5];
   word_t  exp_flat [64];
   block_t got_blk [8];
   logic   got_f [8];
   logic   got_l [8];
   int     passed = 0;
   int     total = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_blk(input string name, input block_t a,
                            input int bi);
      int bad = -1;
      for (int k = 15; k >= 0; k--)
         if (a[k] !== exp_flat[bi*16+k]) bad = k;
      total++;
      if (bad < 0)
         passed++;
      else
         $display("FAIL %s blk%0d word%0d: got %h expected %h",
                  name, bi, bad, a[bad], exp_flat[bi*16+bad]);
   endtask

   function automatic word_t word_of(input vec_t v, input int i);
      return (i == 0) ? v.w0 : word_t'(i + 1);
   endfunction

   task automatic build_exp(input vec_t v);
      for (int k = 0; k < 64; k++) exp_flat[k] = '0;
      for (int i = 0; i < v.n; i++) exp_flat[i] = word_of(v, i);
      exp_flat[v.exp_pad] = 32'h8000_0000;
      exp_flat[v.exp_blocks*16-1] = v.exp_len;
   endtask

   task automatic check_outs_zero(input int d, input string tag);
      check({tag, "_in_ready"}, 32'(in_ready_v[d]), 0);
      check({tag, "_blk_valid"}, 32'(blk_valid_v[d]), 0);
      check({tag, "_flags"},
            32'({blk_first_v[d], blk_last_v[d]}), 0);
      check({tag, "_busy"}, 32'(busy_v[d]), 0);
      check({tag, "_done"}, 32'(done_v[d]), 0);
      check({tag, "_data_or"}, 32'(|blk_data_v[d]), 0);
   endtask

   task automatic run_msg(input vec_t v, output int nrecv,
                          output int ndone);
      int d = v.dut;
      int sent = 0;
      int hold = 0;
      int stall = 0;
      int cyc = 0;
      bit fin = 0;
      nrecv = 0;
      ndone = 0;
      @(negedge clk);
      blk_ready = 1'b1;
      in_valid = 1'b0;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      while (!fin && cyc < 3000) begin
         cyc++;
         if (done_v[d]) begin
            ndone++;
            fin = 1;
            break;
         end
         start_v[d] = (cyc == v.busy_start);
         if (cyc == v.busy_start)
            check("busy_at_restart", 32'(busy_v[d]), 1);
         if (v.stall_at >= 0 && sent == v.stall_at && stall < 3) begin
            in_valid = 1'b0;
            stall++;
         end else begin
            in_valid = 1'b1;
         end
         in_data = (sent < v.n) ? word_of(v, sent) : 32'hBAD0_BAD0;
         if (in_valid && in_ready_v[d]) sent++;
         if (nrecv == 0 && hold > 0 && hold < v.bp)
            check("bp_valid_held", 32'(blk_valid_v[d]), 1);
         blk_ready = 1'b1;
         if (blk_valid_v[d]) begin
            if (nrecv == 0 && hold < v.bp) begin
               blk_ready = 1'b0;
               check_blk("bp_data_held", blk_data_v[d], 0);
               check("bp_in_ready", 32'(in_ready_v[d]), 0);
               hold++;
            end else if (nrecv < 8) begin
               got_blk[nrecv] = blk_data_v[d];
               got_f[nrecv] = blk_first_v[d];
               got_l[nrecv] = blk_last_v[d];
               nrecv++;
            end
         end
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      in_valid = 1'b0;
      if (!fin) check("timeout_done", 0, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done_v[d]) ndone++;
      end
   endtask

   task automatic verify(input vec_t v, input string tag);
      int nrecv;
      int ndone;
      build_exp(v);
      run_msg(v, nrecv, ndone);
      check({tag, "_nblocks"}, 32'(nrecv), 32'(v.exp_blocks));
      check({tag, "_done_pulses"}, 32'(ndone), 1);
      for (int b = 0; b < nrecv && b < v.exp_blocks; b++) begin
         check_blk({tag, "_data"}, got_blk[b], b);
         check({tag, "_first"}, 32'(got_f[b]), 32'(b == 0));
         check({tag, "_last"}, 32'(got_l[b]),
               32'(b == v.exp_blocks - 1));
      end
   endtask

   initial begin
      int cyc;
      int sent;
      for (int d = 0; d < 4; d++) start_v[d] = 1'b0;
      vecs[0] = '{0, 20, 32'd1, -1, 0, -1, 2, 20, 32'h280};
      vecs[1] = '{1, 1, 32'hDEAD_BEEF, -1, 0, -1, 1, 1, 32'h20};
      vecs[2] = '{2, 14, 32'd1, -1, 0, -1, 2, 14, 32'h1C0};
      vecs[3] = '{3, 16, 32'd1, -1, 0, -1, 2, 16, 32'h200};
      vecs[4] = '{0, 20, 32'd1, 9, 5, 12, 2, 20, 32'h280};

      #3;
      for (int d = 0; d < 4; d++) check_outs_zero(d, "reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++)
         verify(vecs[i], $sformatf("vec%0d", i));

      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      sent = 0;
      cyc = 0;
      while (sent < 7 && cyc < 100) begin
         cyc++;
         in_valid = 1'b1;
         in_data = word_t'(sent + 1);
         if (in_ready_v[0]) sent++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("midmsg_busy", 32'(busy_v[0]), 1);
      #2 reset_n = 1'b0;
      #1 check_outs_zero(0, "midreset");
      @(negedge clk);
      check_outs_zero(0, "midreset_hold");
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("no_done_after_reset", 32'(done_v[0]), 0);
      end
      verify(vecs[0], "after_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
